// File: rtl/fp_collect_pkg.sv
// rtl/fp_collect_pkg.sv - IEEE-754 single field constants, class bit indices and classifier
package fp_collect_pkg;

    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int MANT_MSB = 22;

    localparam logic [7:0] EXP_ALL_ONES = 8'hFF;

    localparam int CLS_NAN  = 3;
    localparam int CLS_INF  = 2;
    localparam int CLS_ZERO = 1;
    localparam int CLS_NEG  = 0;

    typedef logic [3:0] fp_class_t;

    // Denormals classify as zero because the adder flushes them.
    function automatic fp_class_t fp_classify(input logic [31:0] v);
        logic [7:0]        e;
        logic [MANT_MSB:0] m;
        fp_class_t         c;
        e           = v[EXP_MSB:EXP_LSB];
        m           = v[MANT_MSB:0];
        c           = '0;
        c[CLS_NAN]  = (e == EXP_ALL_ONES) && (m != '0);
        c[CLS_INF]  = (e == EXP_ALL_ONES) && (m == '0);
        c[CLS_ZERO] = (e == '0);
        c[CLS_NEG]  = v[SIGN_BIT];
        return c;
    endfunction

endpackage

// File: rtl/fpadd_result_collector_if.sv
// rtl/fpadd_result_collector_if.sv - issue and result-drain signals of the adder result collector
interface fpadd_result_collector_if #(
    parameter int LATENCY = 4,
    parameter int TAG_W   = 4
);
    localparam int IF_W = $clog2(LATENCY + 1);

    logic             issue_valid;
    logic             issue_ready;
    logic [31:0]      sum;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [TAG_W-1:0] out_tag;
    logic [3:0]       out_class;
    logic [IF_W-1:0]  in_flight;

    modport master (
        output issue_valid, sum, out_ready,
        input  issue_ready, out_valid, out_data, out_tag, out_class, in_flight
    );

    modport slave (
        input  issue_valid, sum, out_ready,
        output issue_ready, out_valid, out_data, out_tag, out_class, in_flight
    );

endinterface

// File: rtl/fp_collect_fifo.sv
// rtl/fp_collect_fifo.sv - synchronous show-ahead FIFO; head is visible with no read latency
module fp_collect_fifo
    import fp_collect_pkg::*;
#(
    parameter  int WIDTH = 36,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Empty head reads as zero so the outputs are defined straight out of reset.
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/fpadd_result_collector.sv
// rtl/fpadd_result_collector.sv - tags adder issues, captures sums LATENCY cycles later into a credit-guarded FIFO
// FP_CLASSIFY_EN adds {nan,inf,zero,neg} class bits per captured entry.
module fpadd_result_collector
    import fp_collect_pkg::*;
#(
    parameter int LATENCY = 4,
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    fpadd_result_collector_if.slave  bus
);

    localparam int IF_W  = $clog2(LATENCY + 1);
    localparam int CNT_W = $clog2(DEPTH + 1);
`ifdef FP_CLASSIFY_EN
    localparam int ENT_W = 32 + TAG_W + 4;
`else
    localparam int ENT_W = 32 + TAG_W;
`endif

    logic [TAG_W-1:0]              seq_q;
    logic [LATENCY-1:0]            vld_q;
    logic [LATENCY-1:0][TAG_W-1:0] tag_q;
    logic [IF_W-1:0]               in_flight_q;
    logic [CNT_W-1:0]              fifo_count;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic                          accept;
    logic                          capture;
    logic                          pop;
    logic [ENT_W-1:0]              push_data;
    logic [ENT_W-1:0]              head;

    // Credit counts results already buffered plus those still in the adder.
    assign bus.issue_ready = (int'(fifo_count) + int'(in_flight_q)) < DEPTH;
    assign accept          = bus.issue_valid && bus.issue_ready;
    assign capture         = vld_q[LATENCY-1];
    assign bus.out_valid   = !fifo_empty;
    assign pop             = bus.out_valid && bus.out_ready;
    assign bus.in_flight   = in_flight_q;

`ifdef FP_CLASSIFY_EN
    assign push_data     = {bus.sum, tag_q[LATENCY-1], fp_classify(bus.sum)};
    assign bus.out_class = head[3:0];
    assign bus.out_tag   = head[4 +: TAG_W];
`else
    assign push_data     = {bus.sum, tag_q[LATENCY-1]};
    assign bus.out_class = 4'b0000;
    assign bus.out_tag   = head[0 +: TAG_W];
`endif
    assign bus.out_data  = head[ENT_W-1 -: 32];

    always_ff @(posedge clk) begin
        if (rst) begin
            seq_q       <= '0;
            vld_q       <= '0;
            tag_q       <= '0;
            in_flight_q <= '0;
        end else begin
            if (accept) begin
                seq_q <= seq_q + TAG_W'(1);
            end
            vld_q[0] <= accept;
            tag_q[0] <= seq_q;
            for (int i = 1; i < LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                tag_q[i] <= tag_q[i-1];
            end
            if (accept && !capture) begin
                in_flight_q <= in_flight_q + IF_W'(1);
            end else if (!accept && capture) begin
                in_flight_q <= in_flight_q - IF_W'(1);
            end
        end
    end

    fp_collect_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (capture),
        .din   (push_data),
        .pop   (pop),
        .dout  (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assert property (@(posedge clk) disable iff (rst) !(capture && fifo_full && !pop));

endmodule

// File: tb/tb_fpadd_result_collector.sv
// tb/tb_fpadd_result_collector.sv - directed and table-driven checks of fpadd_result_collector
`timescale 1ns/1ps
module tb_fpadd_result_collector;

    localparam int          LAT  = 4;
    localparam int          DEP  = 4;
    localparam logic [31:0] JUNK = 32'hBAD0_BAD0;
`ifdef FP_CLASSIFY_EN
    localparam bit CLS_ON = 1'b1;
`else
    localparam bit CLS_ON = 1'b0;
`endif

    typedef struct {
        logic [31:0] sum;
        logic [3:0]  cls;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] nv = 32'h0;
    logic [31:0] pipe [LAT];
    vec_t        vecs [8];

    always #5 clk = ~clk;

    fpadd_result_collector_if #(.LATENCY(LAT), .TAG_W(4)) m  ();
    fpadd_result_collector_if #(.LATENCY(LAT), .TAG_W(2)) m2 ();

    assign m2.issue_valid = m.issue_valid;
    assign m2.sum         = m.sum;
    assign m2.out_ready   = m.out_ready;

    fpadd_result_collector #(.LATENCY(LAT), .DEPTH(DEP), .TAG_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (m)
    );

    fpadd_result_collector #(.LATENCY(LAT), .DEPTH(DEP), .TAG_W(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (m2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Acts as the adder: whatever is issued in cycle t appears on sum in cycle t+LAT.
    task automatic tick();
        @(posedge clk);
        for (int i = LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
        pipe[0] = m.issue_valid ? nv : JUNK;
        @(negedge clk);
        m.sum = pipe[LAT-1];
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m.issue_valid = 1'b0;
        m.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < LAT; i++) pipe[i] = JUNK;
        m.sum = JUNK;
        m.issue_valid = 1'b0;
        m.out_ready = 1'b0;

        vecs[0] = '{sum: 32'hD4FF_ABFA, cls: 4'b0001};
        vecs[1] = '{sum: 32'h7F80_0000, cls: 4'b0100};
        vecs[2] = '{sum: 32'h7FC0_0000, cls: 4'b1000};
        vecs[3] = '{sum: 32'h8000_0000, cls: 4'b0011};
        vecs[4] = '{sum: 32'h3F80_0000, cls: 4'b0000};
        vecs[5] = '{sum: 32'h0000_0001, cls: 4'b0010};
        vecs[6] = '{sum: 32'hFF80_0000, cls: 4'b0101};
        vecs[7] = '{sum: 32'hFFFF_FFFF, cls: 4'b1001};

        // reset state
        tick();
        tick();
        chk("rst issue_ready", 32'(m.issue_ready), 32'd1);
        chk("rst out_valid",   32'(m.out_valid),   32'd0);
        chk("rst out_data",    m.out_data,         32'd0);
        chk("rst out_tag",     32'(m.out_tag),     32'd0);
        chk("rst out_class",   32'(m.out_class),   32'd0);
        chk("rst in_flight",   32'(m.in_flight),   32'd0);
        rst = 1'b0;

        // single spaced issues: latency, capture, class, tag wrap on the TAG_W=2 instance
        for (int k = 0; k < 8; k++) begin
            m.issue_valid = 1'b1;
            nv = vecs[k].sum;
            m.out_ready = 1'b1;
            tick();
            m.issue_valid = 1'b0;
            for (int c = 1; c <= LAT; c++) begin
                chk($sformatf("v%0d c%0d out_valid", k, c), 32'(m.out_valid), 32'd0);
                chk($sformatf("v%0d c%0d in_flight", k, c), 32'(m.in_flight), 32'd1);
                tick();
            end
            chk($sformatf("v%0d out_valid", k),   32'(m.out_valid),  32'd1);
            chk($sformatf("v%0d out_data", k),    m.out_data,        vecs[k].sum);
            chk($sformatf("v%0d out_tag", k),     32'(m.out_tag),    32'(k % 16));
            chk($sformatf("v%0d tag2", k),        32'(m2.out_tag),   32'(k % 4));
            chk($sformatf("v%0d out_class", k),   32'(m.out_class),  32'(CLS_ON ? vecs[k].cls : 4'b0000));
            chk($sformatf("v%0d in_flight", k),   32'(m.in_flight),  32'd0);
            chk($sformatf("v%0d issue_ready", k), 32'(m.issue_ready), 32'd1);
            tick();
            chk($sformatf("v%0d drained", k),     32'(m.out_valid),  32'd0);
        end

        // back-to-back issues fill the credit; refused issues must not be tracked
        do_reset();
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("b2b c%0d issue_ready", c), 32'(m.issue_ready), 32'd1);
            m.issue_valid = 1'b1;
            nv = 32'h4000_0000 + 32'(c);
            tick();
        end
        nv = 32'h7777_7777;
        for (int c = 4; c < 8; c++) begin
            chk($sformatf("b2b c%0d issue_ready", c), 32'(m.issue_ready), 32'd0);
            tick();
        end
        m.issue_valid = 1'b0;
        chk("b2b c8 issue_ready", 32'(m.issue_ready), 32'd0);
        chk("b2b c8 in_flight",   32'(m.in_flight),   32'd0);
        chk("b2b c8 out_valid",   32'(m.out_valid),   32'd1);
        chk("b2b c8 out_data",    m.out_data,         32'h4000_0000);
        chk("b2b c8 out_tag",     32'(m.out_tag),     32'd0);
        m.out_ready = 1'b1;
        tick();
        for (int j = 1; j < 4; j++) begin
            chk($sformatf("b2b pop%0d issue_ready", j), 32'(m.issue_ready), 32'd1);
            chk($sformatf("b2b pop%0d out_data", j),    m.out_data,         32'h4000_0000 + 32'(j));
            chk($sformatf("b2b pop%0d out_tag", j),     32'(m.out_tag),     32'(j));
            tick();
        end
        chk("b2b empty out_valid", 32'(m.out_valid), 32'd0);
        tick();
        tick();
        tick();
        chk("b2b refused not captured", 32'(m.out_valid), 32'd0);

        // count=3 with a pop and a capture on the same edge
        do_reset();
        for (int c = 0; c < 4; c++) begin
            m.issue_valid = 1'b1;
            nv = 32'h5000_0000 + 32'(c);
            tick();
        end
        m.issue_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("pp c7 issue_ready", 32'(m.issue_ready), 32'd0);
        chk("pp c7 in_flight",   32'(m.in_flight),   32'd1);
        chk("pp c7 out_tag",     32'(m.out_tag),     32'd0);
        m.out_ready = 1'b1;
        tick();
        chk("pp c8 issue_ready", 32'(m.issue_ready), 32'd1);
        for (int j = 1; j < 4; j++) begin
            chk($sformatf("pp head%0d out_valid", j), 32'(m.out_valid), 32'd1);
            chk($sformatf("pp head%0d out_data", j),  m.out_data,       32'h5000_0000 + 32'(j));
            chk($sformatf("pp head%0d out_tag", j),   32'(m.out_tag),   32'(j));
            tick();
        end
        chk("pp empty out_valid", 32'(m.out_valid), 32'd0);

        // reset while two issues are in flight
        do_reset();
        m.issue_valid = 1'b1;
        nv = 32'h6000_0000;
        tick();
        nv = 32'h6000_0001;
        tick();
        m.issue_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid in_flight",   32'(m.in_flight),   32'd0);
        chk("rstmid issue_ready", 32'(m.issue_ready), 32'd1);
        for (int c = 3; c < 11; c++) begin
            chk($sformatf("rstmid c%0d out_valid", c), 32'(m.out_valid), 32'd0);
            tick();
        end
        m.issue_valid = 1'b1;
        nv = 32'h3F80_0000;
        tick();
        m.issue_valid = 1'b0;
        for (int c = 0; c < LAT; c++) tick();
        chk("rstmid new out_valid", 32'(m.out_valid), 32'd1);
        chk("rstmid new out_data",  m.out_data,       32'h3F80_0000);
        chk("rstmid new out_tag",   32'(m.out_tag),   32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
